// File: rtl/vga_mem_arbiter.sv
// Single-port VGA memory arbiter: display reads win, CPU writes queue
// in a small FIFO and are forwarded to reads until they drain.
module vga_mem_arbiter #(
  parameter int ADDRW   = 8,
  parameter int DATAW   = 32,
  parameter int FIFO_AW = 2
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               rd_req,
  input  logic [ADDRW-1:0]   rd_addr,
  output logic               rd_valid,
  output logic [DATAW-1:0]   rd_data,
  input  logic               wr_req,
  input  logic [ADDRW-1:0]   wr_addr,
  input  logic [DATAW-1:0]   wr_data,
  output logic               wr_ready,
  output logic [ADDRW-1:0]   mem_addr,
  output logic               mem_we,
  output logic [DATAW-1:0]   mem_wdata,
  input  logic [DATAW-1:0]   mem_rdata,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

  logic [ADDRW-1:0]   f_addr [DEPTH];
  logic [DATAW-1:0]   f_data [DEPTH];
  logic [FIFO_AW-1:0] head;
  logic [FIFO_AW-1:0] tail;
  logic [FIFO_AW:0]   count;

  logic               rd_vld;
  logic               fwd_hit;
  logic [DATAW-1:0]   fwd_data;

  logic               full;
  logic               push;
  logic               pop;
  logic               hit;
  logic [DATAW-1:0]   hit_data;

  assign full     = (count == FULL);
  assign push     = wr_req & ~full;
  assign pop      = ~rd_req & (count != '0);
  assign wr_ready = ~full | ~iRST_n;

  assign mem_we    = pop & iRST_n;
  assign mem_addr  = mem_we ? f_addr[head] : rd_addr;
  assign mem_wdata = mem_we ? f_data[head] : '0;

  assign fifo_count = count;
  assign rd_valid   = rd_vld;
  assign rd_data    = !rd_vld ? '0 :
                      fwd_hit ? fwd_data : mem_rdata;

  // Scan oldest to youngest so the last match wins; a same-cycle
  // write is younger than everything already queued.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((FIFO_AW+1)'(i) < count &&
          f_addr[head + FIFO_AW'(i)] == rd_addr) begin
        hit      = 1'b1;
        hit_data = f_data[head + FIFO_AW'(i)];
      end
    end
    if (push && wr_addr == rd_addr) begin
      hit      = 1'b1;
      hit_data = wr_data;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (push && iRST_n) begin
      f_addr[tail] <= wr_addr;
      f_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rd_vld   <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && full) overflow <= 1'b1;
      rd_vld   <= rd_req;
      fwd_hit  <= rd_req & hit;
      fwd_data <= hit_data;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  fifo_count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Registered single-port memory owned by the bench.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {24'hC0FFEE, 8'(i)};
      ref_mem[i] = {24'hC0FFEE, 8'(i)};
    end
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: pending writes as a queue, memory as an array.
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  logic        m_ovf = 1'b0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_pop;
  logic        m_acc;
  logic [31:0] m_v;
  logic [7:0]  m_exp_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst wr_ready", 32'(wr_ready), 32'd1);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'(rd_addr));
      q.delete();
      m_ovf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      m_pop = !rd_req && q.size() > 0;
      m_exp_addr = m_pop ? q[0].a : rd_addr;
      chk("wr_ready", 32'(wr_ready), 32'(q.size() != 4));
      chk("mem_we", 32'(mem_we), 32'(m_pop));
      chk("mem_addr", 32'(mem_addr), 32'(m_exp_addr));
      if (m_pop) chk("mem_wdata", mem_wdata, q[0].d);
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("rd_data", rd_data, m_rv ? m_rd : 32'd0);
      m_acc = wr_req && q.size() != 4;
      if (wr_req && !m_acc) m_ovf = 1'b1;
      if (rd_req) begin
        m_v = ref_mem[rd_addr];
        foreach (q[i]) if (q[i].a == rd_addr) m_v = q[i].d;
        if (m_acc && wr_addr == rd_addr) m_v = wr_data;
        m_rd = m_v;
      end
      m_rv = rd_req;
      if (m_pop) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (m_acc) q.push_back('{wr_addr, wr_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    step();
    step();
    rst_n = 1'b1;

    @(negedge clk);
    chk("idle wr_ready", 32'(wr_ready), 32'd1);
    chk("idle mem_we", 32'(mem_we), 32'd0);
    chk("idle rd_valid", 32'(rd_valid), 32'd0);
    chk("idle fifo_count", 32'(fifo_count), 32'd0);
    chk("idle overflow", 32'(overflow), 32'd0);

    // Single write on an idle port drains the next cycle.
    step();
    wr_req  = 1'b1;
    wr_addr = 8'h10;
    wr_data = 32'hDEADBEEF;
    step();
    idle();
    @(negedge clk);
    chk("w1 mem_we", 32'(mem_we), 32'd1);
    chk("w1 mem_addr", 32'(mem_addr), 32'h10);
    chk("w1 mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w1 count", 32'(fifo_count), 32'd1);
    step();
    @(negedge clk);
    chk("w1 drained", 32'(fifo_count), 32'd0);

    // Fill under continuous reads, then overflow.
    for (int k = 0; k < 10; k++) begin
      step();
      rd_req  = 1'b1;
      rd_addr = 8'h00;
      wr_req  = (k < 5);
      wr_addr = 8'h40 + 8'(k);
      wr_data = 32'h100 + 32'(k);
      @(negedge clk);
      if (k == 4) chk("full wr_ready", 32'(wr_ready), 32'd0);
      if (k == 5) chk("ovf set", 32'(overflow), 32'd1);
      if (k == 5) chk("full count", 32'(fifo_count), 32'd4);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      idle();
      @(negedge clk);
      chk("drain we", 32'(mem_we), 32'd1);
      chk("drain addr", 32'(mem_addr), 32'h40 + 32'(k));
      chk("drain data", mem_wdata, 32'h100 + 32'(k));
    end
    step();
    @(negedge clk);
    chk("drain done we", 32'(mem_we), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);

    // Forward youngest of two queued writes to the same address.
    step();
    rd_req  = 1'b1;
    rd_addr = 8'h00;
    wr_req  = 1'b1;
    wr_addr = 8'h20;
    wr_data = 32'd1;
    step();
    wr_data = 32'd2;
    step();
    wr_req  = 1'b0;
    rd_addr = 8'h20;
    step();
    rd_addr = 8'h21;
    @(negedge clk);
    chk("fwd 0x20", rd_data, 32'd2);
    step();
    idle();
    @(negedge clk);
    chk("mem 0x21", rd_data, 32'hC0FFEE21);
    step();
    step();
    step();

    // Same-cycle write and read of one address.
    rd_req  = 1'b1;
    rd_addr = 8'h30;
    wr_req  = 1'b1;
    wr_addr = 8'h30;
    wr_data = 32'h55;
    step();
    idle();
    @(negedge clk);
    chk("fwd same cyc", rd_data, 32'h55);
    step();
    step();
    rd_req  = 1'b1;
    rd_addr = 8'h20;
    step();
    idle();
    @(negedge clk);
    chk("mem 0x20 final", rd_data, 32'd2);

    // Reset discards queued writes and an in-flight read.
    for (int k = 0; k < 3; k++) begin
      step();
      rd_req  = 1'b1;
      rd_addr = 8'h50;
      wr_req  = 1'b1;
      wr_addr = 8'h60 + 8'(k);
      wr_data = 32'hA0 + 32'(k);
    end
    step();
    wr_req  = 1'b0;
    rst_n   = 1'b0;
    rd_addr = 8'h60;
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("post rst rd_valid", 32'(rd_valid), 32'd0);
    chk("post rst count", 32'(fifo_count), 32'd0);
    chk("post rst mem_we", 32'(mem_we), 32'd0);
    chk("post rst ovf", 32'(overflow), 32'd0);
    step();
    step();
    rd_req  = 1'b1;
    rd_addr = 8'h61;
    step();
    idle();
    @(negedge clk);
    chk("discarded 0x61", rd_data, 32'hC0FFEE61);
    chk("discarded 0x60", mem[8'h60], 32'hC0FFEE60);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
